// File: rtl/line_scan_timing_gen.sv
// line_scan_timing_gen
// Turns the 32-bit PIO control word into line-scan sensor timing:
//   - start pulse (SI)
//   - divided pixel clock
//   - per-pixel capture strobes with index
//   - end-of-line pulse and completed-line counter
// Every output comes straight from a flop.
module line_scan_timing_gen #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [31:0]      ctrl_word,
   output logic             sensor_si,
   output logic             sensor_clk,
   output logic             pix_strobe,
   output logic [9:0]       pix_index,
   output logic             line_done,
   output logic [CNT_W-1:0] line_count,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      START   = 2'd1,
      READOUT = 2'd2,
      GAP     = 2'd3
   } state_t;

   state_t state_r, state_s;

   // control word fields as seen this cycle
   logic        run_s;
   logic        oneshot_s;
   assign run_s     = ctrl_word[0];
   assign oneshot_s = ctrl_word[1];

   // shadow copies of the line geometry, frozen for the whole line
   logic [9:0]  n_sh_r,  n_sh_s;
   logic [15:0] g_sh_r,  g_sh_s;
   logic [3:0]  d_sh_r,  d_sh_s;

   logic [3:0]  div_cnt_r, div_cnt_s;
   logic [15:0] gap_cnt_r, gap_cnt_s;
   logic [10:0] pix_cnt_r, pix_cnt_s;   // pixels strobed so far in this line
   logic        single_r,  single_s;
   logic        oneshot_q_r;

   logic             si_s;
   logic             sclk_s;
   logic             strobe_s;
   logic [9:0]       pix_index_s;
   logic             line_done_s;
   logic [CNT_W-1:0] line_count_s;

   logic        tick_s;                 // divider reached its terminal count
   logic [10:0] npix_s;                 // N = 0 encodes a full 1024-pixel line
   logic        enter_start_s;
   logic        enter_idle_s;

   assign tick_s = (div_cnt_r == d_sh_r);
   assign npix_s = (n_sh_r == 10'd0) ? 11'd1024 : {1'b0, n_sh_r};

   // Next-state, next-output and datapath decode
   always_comb begin
      state_s       = state_r;
      n_sh_s        = n_sh_r;
      g_sh_s        = g_sh_r;
      d_sh_s        = d_sh_r;
      div_cnt_s     = div_cnt_r;
      gap_cnt_s     = gap_cnt_r;
      pix_cnt_s     = pix_cnt_r;
      single_s      = single_r;
      si_s          = sensor_si;
      sclk_s        = sensor_clk;
      strobe_s      = 1'b0;
      pix_index_s   = pix_index;
      line_done_s   = 1'b0;
      line_count_s  = line_count;
      enter_start_s = 1'b0;
      enter_idle_s  = 1'b0;

      case (state_r)
         IDLE: begin
            si_s   = 1'b0;
            sclk_s = 1'b0;
            if (run_s) begin
               enter_start_s = 1'b1;
            end else if (oneshot_s && !oneshot_q_r) begin
               enter_start_s = 1'b1;
               single_s      = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end

         START: begin
            if (tick_s) begin
               div_cnt_s = 4'd0;
               sclk_s    = ~sensor_clk;
               if (sensor_clk) begin
                  // falling edge closes the SI period
                  si_s      = 1'b0;
                  state_s   = READOUT;
                  pix_cnt_s = 11'd0;
               end else begin
                  si_s = 1'b1;
               end
            end else begin
               div_cnt_s = div_cnt_r + 4'd1;
            end
         end

         READOUT: begin
            if (tick_s) begin
               div_cnt_s = 4'd0;
               if (!sensor_clk) begin
                  // rising edge: capture strobe for the next pixel
                  sclk_s      = 1'b1;
                  strobe_s    = 1'b1;
                  pix_index_s = pix_cnt_r[9:0];
                  pix_cnt_s   = pix_cnt_r + 11'd1;
               end else begin
                  sclk_s = 1'b0;
                  if (pix_cnt_r == npix_s) begin
                     line_done_s  = 1'b1;
                     line_count_s = line_count + CNT_W'(1);
                     if (g_sh_r != 16'd0) begin
                        state_s   = GAP;
                        gap_cnt_s = 16'd1;
                     end else if (run_s && !single_r) begin
                        enter_start_s = 1'b1;
                     end else begin
                        enter_idle_s = 1'b1;
                     end
                  end else begin
                     state_s = READOUT;
                  end
               end
            end else begin
               div_cnt_s = div_cnt_r + 4'd1;
            end
         end

         GAP: begin
            sclk_s = 1'b0;
            si_s   = 1'b0;
            if (gap_cnt_r == g_sh_r) begin
               if (run_s && !single_r) begin
                  enter_start_s = 1'b1;
               end else begin
                  enter_idle_s = 1'b1;
               end
            end else begin
               gap_cnt_s = gap_cnt_r + 16'd1;
            end
         end

         default: begin
            enter_idle_s = 1'b1;
         end
      endcase

      // common actions for entering START or IDLE
      if (enter_start_s) begin
         state_s   = START;
         n_sh_s    = ctrl_word[11:2];
         g_sh_s    = ctrl_word[27:12];
         d_sh_s    = ctrl_word[31:28];
         div_cnt_s = 4'd0;
         si_s      = 1'b1;
         sclk_s    = 1'b0;
      end else if (enter_idle_s) begin
         state_s  = IDLE;
         single_s = 1'b0;
         si_s     = 1'b0;
         sclk_s   = 1'b0;
      end else begin
         state_s = state_s;
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Shadow fields, counters and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         n_sh_r      <= 10'd0;
         g_sh_r      <= 16'd0;
         d_sh_r      <= 4'd0;
         div_cnt_r   <= 4'd0;
         gap_cnt_r   <= 16'd0;
         pix_cnt_r   <= 11'd0;
         single_r    <= 1'b0;
         oneshot_q_r <= 1'b0;
         sensor_si   <= 1'b0;
         sensor_clk  <= 1'b0;
         pix_strobe  <= 1'b0;
         pix_index   <= 10'd0;
         line_done   <= 1'b0;
         line_count  <= '0;
         busy        <= 1'b0;
      end else begin
         n_sh_r      <= n_sh_s;
         g_sh_r      <= g_sh_s;
         d_sh_r      <= d_sh_s;
         div_cnt_r   <= div_cnt_s;
         gap_cnt_r   <= gap_cnt_s;
         pix_cnt_r   <= pix_cnt_s;
         single_r    <= single_s;
         oneshot_q_r <= oneshot_s;
         sensor_si   <= si_s;
         sensor_clk  <= sclk_s;
         pix_strobe  <= strobe_s;
         pix_index   <= pix_index_s;
         line_done   <= line_done_s;
         line_count  <= line_count_s;
         busy        <= (state_s != IDLE);
      end
   end

endmodule

// File: tb/tb_line_scan_timing_gen.sv
// Bench for line_scan_timing_gen.
// Expected per-cycle output records are derived from the line-timing formulas,
// queued when stimulus is applied, and popped and compared each cycle.
// A second instance with CNT_W = 4 runs in lockstep to exercise counter wrap.
`timescale 1ns/1ps
module tb_line_scan_timing_gen;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] ctrl_word;

   logic        si_a, sclk_a, strobe_a, done_a, busy_a;
   logic [9:0]  idx_a;
   logic [15:0] lc_a;
   logic        si_b, sclk_b, strobe_b, done_b, busy_b;
   logic [9:0]  idx_b;
   logic [3:0]  lc_b;

   line_scan_timing_gen #(.CNT_W(16)) dut_a (
      .clk(clk), .reset_n(reset_n), .ctrl_word(ctrl_word),
      .sensor_si(si_a), .sensor_clk(sclk_a), .pix_strobe(strobe_a),
      .pix_index(idx_a), .line_done(done_a), .line_count(lc_a), .busy(busy_a));

   line_scan_timing_gen #(.CNT_W(4)) dut_b (
      .clk(clk), .reset_n(reset_n), .ctrl_word(ctrl_word),
      .sensor_si(si_b), .sensor_clk(sclk_b), .pix_strobe(strobe_b),
      .pix_index(idx_b), .line_done(done_b), .line_count(lc_b), .busy(busy_b));

   always #5 clk = ~clk;

   typedef struct packed {
      logic        si;
      logic        sclk;
      logic        strobe;
      logic [9:0]  idx;
      logic        done;
      logic        busy;
      logic [15:0] lc;
   } rec_t;

   typedef struct {
      int d; int n; int g; int lines;
      int exp_period; int exp_strobes;
   } vec_t;

   rec_t        exp_q[$];
   int          rises[$];
   vec_t        vecs[5];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          strobe_cnt = 0;
   int          done_cnt = 0;
   int          last_idx = 0;
   logic        si_prev = 1'b0;
   logic [9:0]  exp_idx = 10'd0;
   logic [15:0] exp_lc = 16'd0;
   logic        pend_done = 1'b0;

   function automatic logic [31:0] mk_ctrl(int d, int n, int g, logic run, logic os);
      return {4'(d), 16'(g), 10'(n), os, run};
   endfunction

   function automatic void push_rec(logic si, logic sclk, logic strobe, logic busy);
      rec_t r;
      r.si = si; r.sclk = sclk; r.strobe = strobe; r.idx = exp_idx;
      r.done = pend_done; r.busy = busy; r.lc = exp_lc;
      pend_done = 1'b0;
      exp_q.push_back(r);
   endfunction

   // one line: START + READOUT body, then gap, then optional idle tail
   function automatic void push_line(int d, int n, int g, bit last, int idle_n);
      int   p;
      int   np;
      int   len;
      logic sc;
      logic st;
      p   = d + 1;
      np  = (n == 0) ? 1024 : n;
      len = 2 * p * (np + 1);
      for (int o = 0; o < len; o++) begin
         sc = ((o / p) % 2) == 1;
         st = (o >= 2 * p) && sc && ((o % p) == 0);
         if (st) exp_idx = 10'((o - 2 * p) / (2 * p));
         push_rec(o < 2 * p, sc, st, 1'b1);
      end
      exp_lc    = exp_lc + 16'd1;
      pend_done = 1'b1;
      for (int i = 0; i < g; i++) push_rec(1'b0, 1'b0, 1'b0, 1'b1);
      if (last) begin
         for (int i = 0; i < idle_n; i++) push_rec(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endfunction

   function automatic void check_one();
      rec_t e;
      rec_t a;
      rec_t b;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = '{si_a, sclk_a, strobe_a, idx_a, done_a, busy_a, lc_a};
         b = '{si_b, sclk_b, strobe_b, idx_b, done_b, busy_b, {12'd0, lc_b}};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL trace cyc=%0d got si=%b clk=%b stb=%b idx=%0d done=%b busy=%b lc=%0d expected si=%b clk=%b stb=%b idx=%0d done=%b busy=%b lc=%0d",
                     cyc, a.si, a.sclk, a.strobe, a.idx, a.done, a.busy, a.lc,
                     e.si, e.sclk, e.strobe, e.idx, e.done, e.busy, e.lc);
         end
         e.lc = {12'd0, e.lc[3:0]};
         checks++;
         if (b !== e) begin
            errors++;
            $display("FAIL trace_w4 cyc=%0d got lc=%0d si=%b stb=%b expected lc=%0d si=%b stb=%b",
                     cyc, b.lc, b.si, b.strobe, e.lc, e.si, e.strobe);
         end
      end
   endfunction

   function automatic void chk(string name, int got, int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, got, want);
      end
   endfunction

   function automatic void check_zero(string name);
      logic [31:0] all_a;
      logic [31:0] all_b;
      all_a = {si_a, sclk_a, strobe_a, idx_a, done_a, busy_a, lc_a};
      all_b = {13'd0, si_b, sclk_b, strobe_b, idx_b, done_b, busy_b, lc_b};
      chk({name, "_a"}, int'(all_a), 0);
      chk({name, "_b"}, int'(all_b), 0);
   endfunction

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (strobe_a) begin
         strobe_cnt++;
         last_idx = int'(idx_a);
      end
      if (done_a) done_cnt++;
      if (si_a && !si_prev) rises.push_back(cyc);
      si_prev = si_a;
      check_one();
   endtask

   // run until the expectation queue empties; optional control writes at given steps
   task automatic drain(int at1, logic [31:0] w1, int at2, logic [31:0] w2);
      int k;
      k = 0;
      while (exp_q.size() > 0) begin
         tick();
         if (k == at1) ctrl_word = w1;
         else if (k == at2) ctrl_word = w2;
         else ctrl_word = ctrl_word;
         k++;
      end
   endtask

   task automatic clear_obs();
      strobe_cnt = 0;
      done_cnt   = 0;
      rises.delete();
   endtask

   initial begin
      //           d  n  g  lines period strobes
      vecs[0] = '{0, 4, 3, 3,  13,   4};
      vecs[1] = '{2, 2, 0, 2,  18,   2};
      vecs[2] = '{1, 3, 1, 2,  17,   3};
      vecs[3] = '{0, 1, 0, 20, 4,    1};
      vecs[4] = '{0, 0, 0, 1,  2050, 1024};

      reset_n   = 1'b0;
      ctrl_word = 32'd0;
      repeat (2) @(negedge clk);
      check_zero("reset_hold");
      reset_n = 1'b1;
      push_rec(1'b0, 1'b0, 1'b0, 1'b0);
      push_rec(1'b0, 1'b0, 1'b0, 1'b0);
      drain(-1, 32'd0, -1, 32'd0);

      // continuous runs, run cleared once the last line has started
      for (int t = 0; t < 5; t++) begin
         clear_obs();
         for (int l = 0; l < vecs[t].lines; l++)
            push_line(vecs[t].d, vecs[t].n, vecs[t].g, l == vecs[t].lines - 1, 3);
         ctrl_word = mk_ctrl(vecs[t].d, vecs[t].n, vecs[t].g, 1'b1, 1'b0);
         drain((vecs[t].lines - 1) * vecs[t].exp_period,
               mk_ctrl(vecs[t].d, vecs[t].n, vecs[t].g, 1'b0, 1'b0), -1, 32'd0);
         chk($sformatf("strobes_v%0d", t), strobe_cnt, vecs[t].exp_strobes * vecs[t].lines);
         chk($sformatf("last_idx_v%0d", t), last_idx, vecs[t].exp_strobes - 1);
         chk($sformatf("done_cnt_v%0d", t), done_cnt, vecs[t].lines);
         chk($sformatf("si_rises_v%0d", t), rises.size(), vecs[t].lines);
         for (int r = 1; r < rises.size(); r++)
            chk($sformatf("line_period_v%0d", t), rises[r] - rises[r-1], vecs[t].exp_period);
      end
      chk("line_count_total", int'(lc_a), 28);
      chk("line_count_wrap4", int'(lc_b), 12);

      // oneshot: a single line; a held oneshot does not retrigger
      clear_obs();
      push_line(1, 3, 0, 1'b1, 8);
      ctrl_word = mk_ctrl(1, 3, 0, 1'b0, 1'b1);
      drain(-1, 32'd0, -1, 32'd0);
      chk("oneshot_strobes", strobe_cnt, 3);
      chk("oneshot_done", done_cnt, 1);
      chk("oneshot_busy", int'(busy_a), 0);
      ctrl_word = mk_ctrl(1, 3, 0, 1'b0, 1'b0);
      push_rec(1'b0, 1'b0, 1'b0, 1'b0);
      drain(-1, 32'd0, -1, 32'd0);

      // run set during a oneshot line: idle for one cycle, then restart
      clear_obs();
      push_line(0, 2, 0, 1'b1, 1);
      push_line(0, 2, 0, 1'b1, 3);
      ctrl_word = mk_ctrl(0, 2, 0, 1'b0, 1'b1);
      drain(3, mk_ctrl(0, 2, 0, 1'b1, 1'b1), 7, mk_ctrl(0, 2, 0, 1'b0, 1'b1));
      chk("os_run_done", done_cnt, 2);
      ctrl_word = 32'd0;
      push_rec(1'b0, 1'b0, 1'b0, 1'b0);
      drain(-1, 32'd0, -1, 32'd0);

      // mid-line: clear run and write N = 8; the line keeps N = 3
      clear_obs();
      push_line(0, 3, 2, 1'b1, 6);
      ctrl_word = mk_ctrl(0, 3, 2, 1'b1, 1'b0);
      drain(3, mk_ctrl(0, 8, 2, 1'b0, 1'b0), -1, 32'd0);
      chk("midline_strobes", strobe_cnt, 3);
      chk("midline_si_rises", rises.size(), 1);

      // asynchronous reset in the middle of READOUT
      push_line(0, 4, 0, 1'b1, 3);
      ctrl_word = mk_ctrl(0, 4, 0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      exp_q.delete();
      #2 reset_n = 1'b0;
      #1 check_zero("async_reset");
      @(negedge clk);
      check_zero("reset_held");
      exp_lc    = 16'd0;
      exp_idx   = 10'd0;
      pend_done = 1'b0;
      clear_obs();
      push_line(0, 4, 0, 1'b1, 3);
      reset_n = 1'b1;
      drain(1, mk_ctrl(0, 4, 0, 1'b0, 1'b0), -1, 32'd0);
      chk("post_reset_strobes", strobe_cnt, 4);
      chk("post_reset_lc", int'(lc_a), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout cyc=%0d expected completion", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/line_scan_timing_gen.md
# line_scan_timing_gen

Sequencer that turns the 32-bit control word written by the HPS through the Avalon PIO into line-scan sensor timing. It generates the start pulse (SI), the sensor pixel clock and per-pixel strobes for the ADC capture stage, and line status counters. Its input is driven directly by the PIO `out_port`. Its outputs feed the sensor pins and the downstream pixel capture logic.

## Interface
Parameters:
- `CNT_W`, default 16: width of `line_count`.

Ports:
- `clk`  in  1: system clock; all logic is single-clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `ctrl_word`  in  32: control word from the PIO.
  - [0] `run`
  - [1] `oneshot`
  - [11:2] `N`: pixel count
  - [27:12] `G`: gap cycles
  - [31:28] `D`: divider
- `sensor_si`  out  1: sensor start pulse.
- `sensor_clk`  out  1: sensor pixel clock.
- `pix_strobe`  out  1: one-cycle strobe per pixel.
- `pix_index`  out  10: index of the current pixel, 0..Npix-1.
- `line_done`  out  1: one-cycle pulse at the end of each line.
- `line_count`  out  CNT_W: number of completed lines; wraps.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- States: IDLE, START, READOUT, GAP. All outputs are registered.
- Field capture: `N`, `G` and `D` are latched into shadow registers on every entry to START. Changes to these fields mid-line have no effect until the next line.
- Pixel count: Npix = `N`, except `N` = 0, which gives Npix = 1024.
- Divider: `div_cnt` counts 0..D while in START or READOUT.
  - When `div_cnt` == D, `sensor_clk` toggles on the next cycle and `div_cnt` returns to 0.
  - `sensor_clk` period = 2(D+1) clk cycles: low half first, then high half.
  - `div_cnt` is reset to 0 on entry to START.
- IDLE:
  - Outputs: `sensor_clk` = 0, `sensor_si` = 0.
  - Go to START if `run` = 1.
  - Otherwise go to START on a 0→1 edge of `oneshot`. Detect the edge against a registered copy of `oneshot`, and set the internal `single` flag.
  - An `oneshot` edge outside IDLE is ignored.
- START:
  - `sensor_si` = 1 for one full `sensor_clk` period.
  - On the falling edge of `sensor_clk` that ends that period: `sensor_si` = 0, go to READOUT.
- READOUT:
  - Each 0→1 transition of `sensor_clk` asserts `pix_strobe` in that same cycle.
  - `pix_index` = k for the k-th pixel (0-based), valid with `pix_strobe`. `pix_index` holds its value otherwise.
  - On the falling edge after pixel Npix-1: pulse `line_done`, increment `line_count` (wraps at 2^CNT_W), then:
    - If G > 0: go to GAP.
    - Else if `run` && !`single`: go to START.
    - Else: go to IDLE.
- GAP:
  - `sensor_clk` = 0. Count G cycles.
  - After G cycles: go to START if `run` && !`single`; otherwise go to IDLE and clear `single`.
- Clearing `run` mid-line never truncates the line. The current line completes, then the block goes to IDLE.
- Setting `run` during a oneshot line does not convert it to continuous operation. The block goes to IDLE, then restarts from IDLE on the next cycle.

## Timing
- Reset: all outputs 0, state IDLE, shadow registers 0, `single` = 0, `line_count` = 0.
- Reset asserted mid-line: all outputs go to 0 immediately (asynchronous).
- Latency: `ctrl_word` change seen at clock edge t causes state START with `sensor_si` = 1 at t+1.
- Line length: 2(D+1)(Npix+1) + G cycles from START entry to the next START entry in continuous run.
  - START lasts 2(D+1) cycles.
  - READOUT lasts 2(D+1)·Npix cycles.
- `line_done` is asserted in the first cycle after READOUT, the cycle in which `sensor_clk` falls.
- `busy` = 1 in the same cycle the state leaves IDLE, and 0 in the first IDLE cycle.

## Test plan
- Continuous run:
  - Stimulus: `run` = 1, N = 4, G = 3, D = 0.
  - Required: SI high in cycles c0–c1; `pix_strobe` at c3, c5, c7, c9 with `pix_index` 0–3; `line_done` at c10; next SI at c13; `line_count` = 3 after 3 lines.
- Divider and zero gap:
  - Stimulus: D = 2, N = 2, G = 0.
  - Required: `sensor_clk` period 6 cycles; line period 18 cycles; no GAP cycles; SI rises in the same cycle as `line_done`.
- Oneshot:
  - Stimulus: `oneshot` 0→1 with `run` = 0, N = 3.
  - Required: exactly one line, 3 strobes, `line_done` once, then IDLE with `busy` = 0. Holding `oneshot` = 1 does not retrigger.
- Mid-line changes:
  - Stimulus: during READOUT, clear `run` and write N = 8.
  - Required: the current line finishes with its original N. Then IDLE, with no further SI.
- N = 0 boundary:
  - Stimulus: N = 0.
  - Required: 1024 strobes per line; last `pix_index` = 1023.
  - Also: with CNT_W = 4, the line counter wraps 15→0.
- Reset mid-readout:
  - Stimulus: assert `reset_n` = 0 in the middle of READOUT.
  - Required: all outputs 0 asynchronously. After release with `run` = 1, SI asserts 1 cycle later and `pix_index` restarts at 0.
